// File: rtl/fft_consts.sv
// Shared FFT constants and types; also carries the AGU stage width and FSM state type.
package fft_consts;

  localparam int unsigned N          = 8;
  localparam int unsigned N_LOG2     = $clog2(N);
  localparam int unsigned DW         = 16;
  localparam int unsigned DW_COMPLEX = 2 * DW;

  typedef struct packed {
    logic signed [DW-1:0] re;
    logic signed [DW-1:0] im;
  } complex_t;

  localparam int unsigned STG_W = (N_LOG2 > 1) ? $clog2(N_LOG2) : 1;
  localparam int unsigned K_W   = (N_LOG2 > 1) ? N_LOG2 - 1 : 1;
  localparam int unsigned TW_W  = (N_LOG2 > 1) ? N_LOG2 - 1 : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } agu_state_t;

endpackage

// File: rtl/fft_agu_ctrl_if.sv
// Butterfly command channel between the AGU (master) and the FFT datapath (slave).
interface fft_agu_ctrl_if;

  logic                               bf_valid;
  logic                               bf_ready;
  logic [fft_consts::N_LOG2-1:0]      idx_a;
  logic [fft_consts::N_LOG2-1:0]      idx_b;
  logic [fft_consts::TW_W-1:0]        tw_addr;
  logic [fft_consts::STG_W-1:0]       stage;
  logic                               last_bf;

  modport master (
    output bf_valid, idx_a, idx_b, tw_addr, stage, last_bf,
    input  bf_ready
  );

  modport slave (
    input  bf_valid, idx_a, idx_b, tw_addr, stage, last_bf,
    output bf_ready
  );

endinterface

// File: rtl/fft_agu_idx.sv
// Combinational butterfly index mapping: (k, stage) -> operand indices and twiddle address.
module fft_agu_idx
  import fft_consts::*;
(
  input  logic [K_W-1:0]    k_i,
  input  logic [STG_W-1:0]  stage_i,
  output logic [N_LOG2-1:0] idx_a_o,
  output logic [N_LOG2-1:0] idx_b_o,
  output logic [TW_W-1:0]   tw_addr_o
);

  logic [N_LOG2-1:0] kx;
  logic [N_LOG2-1:0] half;
  logic [N_LOG2-1:0] pos;
  logic [N_LOG2-1:0] grp;
  logic [N_LOG2-1:0] idx_a;
  logic [STG_W-1:0]  tw_sh;

  // Group index is shifted by stage+1 in two steps so the shift amount never overflows STG_W.
  always_comb begin
    kx        = N_LOG2'(k_i);
    half      = N_LOG2'(1) << stage_i;
    pos       = kx & (half - N_LOG2'(1));
    grp       = kx >> stage_i;
    idx_a     = ((grp << 1) << stage_i) | pos;
    tw_sh     = STG_W'(N_LOG2 - 1) - stage_i;
    idx_a_o   = idx_a;
    idx_b_o   = idx_a | half;
    tw_addr_o = TW_W'(pos << tw_sh);
  end

endmodule

// File: rtl/fft_agu_ctrl.sv
// FFT address-generation controller: walks stages x butterflies with inter-stage drain gaps.
// Optional FFT_AGU_INVERSE_EN adds the inverse input and tw_conj output for IFFT operation.
module fft_agu_ctrl
  import fft_consts::*;
#(
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
`ifdef FFT_AGU_INVERSE_EN
  input  logic inverse,
  output logic tw_conj,
`endif
  output logic busy,
  output logic done,
  fft_agu_ctrl_if.master bf
);

  localparam int unsigned CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [K_W-1:0]   K_LAST   = K_W'(N / 2 - 1);
  localparam logic [STG_W-1:0] STG_LAST = STG_W'(N_LOG2 - 1);

  agu_state_t         state_q, state_d;
  logic [K_W-1:0]     k_q, k_d;
  logic [STG_W-1:0]   stage_q, stage_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               last_q, last_d;
  logic [N_LOG2-1:0]  idx_a_q, idx_a_d, idx_b_q, idx_b_d;
  logic [TW_W-1:0]    tw_q, tw_d;
  logic [N_LOG2-1:0]  idx_a_c, idx_b_c;
  logic [TW_W-1:0]    tw_c;
  logic               hs_c;

  assign hs_c = valid_q & bf.bf_ready;

  // Indices are computed from the next (k, stage) so they land in the same cycle as bf_valid.
  fft_agu_idx u_idx (
    .k_i       (k_d),
    .stage_i   (stage_d),
    .idx_a_o   (idx_a_c),
    .idx_b_o   (idx_b_c),
    .tw_addr_o (tw_c)
  );

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    stage_d = stage_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          k_d     = '0;
          stage_d = '0;
        end
      end
      RUN: begin
        if (hs_c) begin
          if (k_q == K_LAST) begin
            state_d = DRAIN;
            cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
          end else begin
            k_d = k_q + K_W'(1);
          end
        end
      end
      DRAIN: begin
        if (cnt_q == '0) begin
          if (stage_q == STG_LAST) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
            stage_d = stage_q + STG_W'(1);
            k_d     = '0;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        k_d     = '0;
        stage_d = '0;
      end
      default: state_d = IDLE;
    endcase

    valid_d = (state_d == RUN);
    busy_d  = (state_d == RUN) || (state_d == DRAIN);
    done_d  = (state_d == DONE);
    last_d  = (state_d == RUN) && (k_d == K_LAST);
    idx_a_d = valid_d ? idx_a_c : '0;
    idx_b_d = valid_d ? idx_b_c : '0;
    tw_d    = valid_d ? tw_c    : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      stage_q <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      last_q  <= 1'b0;
      idx_a_q <= '0;
      idx_b_q <= '0;
      tw_q    <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      last_q  <= last_d;
      idx_a_q <= idx_a_d;
      idx_b_q <= idx_b_d;
      tw_q    <= tw_d;
    end
  end

`ifdef FFT_AGU_INVERSE_EN
  logic conj_q, conj_d;

  // Direction is latched at start acceptance and held for the whole transform.
  always_comb begin
    conj_d = conj_q;
    if ((state_q == IDLE) && start) conj_d = inverse;
  end

  always_ff @(posedge clk) begin
    if (rst) conj_q <= 1'b0;
    else     conj_q <= conj_d;
  end

  assign tw_conj = conj_q;
`endif

  assign busy        = busy_q;
  assign done        = done_q;
  assign bf.bf_valid = valid_q;
  assign bf.idx_a    = idx_a_q;
  assign bf.idx_b    = idx_b_q;
  assign bf.tw_addr  = tw_q;
  assign bf.stage    = stage_q;
  assign bf.last_bf  = last_q;

endmodule

// File: tb/tb_fft_agu_ctrl.sv
// Self-checking bench for fft_agu_ctrl (N=8, DRAIN_CYCLES=4): table-driven scoreboard of butterfly tuples.
module tb_fft_agu_ctrl;
  import fft_consts::*;

  typedef struct {
    int stg;
    int a;
    int b;
    int tw;
    bit last;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic done;
`ifdef FFT_AGU_INVERSE_EN
  logic inverse;
  logic tw_conj;
  logic exp_conj;
`endif

  fft_agu_ctrl_if bf_if ();

  fft_agu_ctrl #(.DRAIN_CYCLES(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
`ifdef FFT_AGU_INVERSE_EN
    .inverse (inverse),
    .tw_conj (tw_conj),
`endif
    .busy    (busy),
    .done    (done),
    .bf      (bf_if)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int hs_n    = 0;
  int hs_cyc[16];
  int done_cnt = 0;
  bit mon_en  = 1'b0;
  bit stall_q = 1'b0;
  logic [10:0] hold;
  vec_t tbl[12];
  vec_t sbq[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [10:0] tuple_now();
    return {bf_if.idx_a, bf_if.idx_b, bf_if.tw_addr, bf_if.stage, bf_if.last_bf};
  endfunction

  // Monitor: handshakes are judged at negedge, where valid/ready are stable for the coming edge.
  always @(negedge clk) begin
    vec_t e;
    if (mon_en) begin
      if (stall_q) begin
        chk("stall_valid", 32'(bf_if.bf_valid), 32'd1);
        chk("stall_hold", 32'(tuple_now()), 32'(hold));
      end
      stall_q = bf_if.bf_valid && !bf_if.bf_ready;
      hold    = tuple_now();
      if (bf_if.bf_valid && bf_if.bf_ready) begin
        if (sbq.size() == 0) begin
          chk("extra_handshake", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("hs_idx_a", 32'(bf_if.idx_a), 32'(e.a));
          chk("hs_idx_b", 32'(bf_if.idx_b), 32'(e.b));
          chk("hs_tw_addr", 32'(bf_if.tw_addr), 32'(e.tw));
          chk("hs_stage", 32'(bf_if.stage), 32'(e.stg));
          chk("hs_last_bf", 32'(bf_if.last_bf), 32'(e.last));
          if (hs_n < 16) hs_cyc[hs_n] = cyc;
          hs_n++;
        end
      end
      if (done) done_cnt++;
`ifdef FFT_AGU_INVERSE_EN
      if (busy) chk("tw_conj_run", 32'(tw_conj), 32'(exp_conj));
`endif
    end
  end

  task automatic push_all();
    foreach (tbl[i]) sbq.push_back(tbl[i]);
  endtask

  // Launches a transform and returns the start-to-done cycle count (start cycle counted as 1).
  task automatic run_xform(input bit rnd, input bit inv, input bit hold_start, output int cycles);
    int t0;
    hs_n   = 0;
    cycles = -1;
    @(posedge clk);
    #1;
    start = 1'b1;
`ifdef FFT_AGU_INVERSE_EN
    inverse  = inv;
    exp_conj = inv;
`else
    if (inv) $display("inverse ignored in forward-only build");
`endif
    bf_if.bf_ready = 1'b1;
    t0 = cyc;
    push_all();
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      if (!hold_start) start = 1'b0;
      bf_if.bf_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (done) begin
        cycles = cyc - t0 + 1;
        break;
      end
    end
    bf_if.bf_ready = 1'b1;
    if (cycles < 0) chk("timeout_done", 32'd1, 32'd0);
  endtask

  task automatic reset_check(input string nm);
    chk(nm, 32'({busy, done, bf_if.bf_valid, bf_if.last_bf, bf_if.idx_a, bf_if.idx_b,
                 bf_if.tw_addr, bf_if.stage}), 32'd0);
`ifdef FFT_AGU_INVERSE_EN
    chk({nm, "_conj"}, 32'(tw_conj), 32'd0);
`endif
  endtask

  initial begin
    int cycles;
    int d0;
    bit found;

    tbl[0]  = '{0, 0, 1, 0, 1'b0};
    tbl[1]  = '{0, 2, 3, 0, 1'b0};
    tbl[2]  = '{0, 4, 5, 0, 1'b0};
    tbl[3]  = '{0, 6, 7, 0, 1'b1};
    tbl[4]  = '{1, 0, 2, 0, 1'b0};
    tbl[5]  = '{1, 1, 3, 2, 1'b0};
    tbl[6]  = '{1, 4, 6, 0, 1'b0};
    tbl[7]  = '{1, 5, 7, 2, 1'b1};
    tbl[8]  = '{2, 0, 4, 0, 1'b0};
    tbl[9]  = '{2, 1, 5, 1, 1'b0};
    tbl[10] = '{2, 2, 6, 2, 1'b0};
    tbl[11] = '{2, 3, 7, 3, 1'b1};

    rst = 1'b1;
    start = 1'b0;
    bf_if.bf_ready = 1'b0;
`ifdef FFT_AGU_INVERSE_EN
    inverse  = 1'b0;
    exp_conj = 1'b0;
`endif

    // Reset then idle
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    reset_check("reset_state");
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk("idle_quiet", 32'({busy, bf_if.bf_valid, done}), 32'd0);
    end
    mon_en = 1'b1;

    // Full run with ready held high: ordering, latency, drain spacing
    d0 = done_cnt;
    run_xform(1'b0, 1'b0, 1'b0, cycles);
    chk("done_latency", 32'(cycles), 32'd26);
    repeat (2) @(posedge clk);
    #1;
    chk("done_single_pulse", 32'(done_cnt - d0), 32'd1);
    chk("idle_after_done", 32'({busy, done, bf_if.bf_valid}), 32'd0);
    chk("full_sb_empty", 32'(sbq.size()), 32'd0);
    chk("full_hs_count", 32'(hs_n), 32'd12);
    chk("drain_gap_01", 32'(hs_cyc[4] - hs_cyc[3] - 1), 32'd4);
    chk("drain_gap_12", 32'(hs_cyc[8] - hs_cyc[7] - 1), 32'd4);

    // Random backpressure
    run_xform(1'b1, 1'b0, 1'b0, cycles);
    @(posedge clk);
    #1;
    chk("bp_sb_empty", 32'(sbq.size()), 32'd0);
    chk("bp_hs_count", 32'(hs_n), 32'd12);

    // Reset mid-run at stage1 k=2, then a clean rerun
    hs_n = 0;
    @(posedge clk);
    #1;
    start = 1'b1;
    push_all();
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (bf_if.bf_valid && bf_if.stage == 2'd1 && bf_if.idx_a == 3'd4) begin
        found = 1'b1;
        rst   = 1'b1;
        break;
      end
    end
    chk("midrst_reached", 32'(found), 32'd1);
    d0 = done_cnt;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sbq.delete();
    reset_check("midrst_state");
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    chk("midrst_still_idle", 32'({busy, bf_if.bf_valid}), 32'd0);
    run_xform(1'b0, 1'b0, 1'b0, cycles);
    chk("rerun_latency", 32'(cycles), 32'd26);
    @(posedge clk);
    #1;
    chk("rerun_sb_empty", 32'(sbq.size()), 32'd0);
    chk("rerun_hs_count", 32'(hs_n), 32'd12);

    // Start held high across done: restart only from IDLE
    run_xform(1'b0, 1'b1, 1'b1, cycles);
    chk("ovl_latency", 32'(cycles), 32'd26);
    chk("ovl_first_count", 32'(hs_n), 32'd12);
    hs_n = 0;
    push_all();
    @(posedge clk);
    #1;
    chk("ovl_idle_gap", 32'({busy, bf_if.bf_valid, done}), 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("ovl_restart", 32'({busy, bf_if.bf_valid, bf_if.idx_a, bf_if.idx_b, bf_if.tw_addr}),
        32'({1'b1, 1'b1, 3'd0, 3'd1, 2'd0}));
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        found = 1'b1;
        break;
      end
    end
    chk("ovl_second_done", 32'(found), 32'd1);
    @(posedge clk);
    #1;
    chk("ovl_sb_empty", 32'(sbq.size()), 32'd0);
    chk("ovl_hs_count", 32'(hs_n), 32'd12);

    // Reset clears everything, including the captured direction
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    reset_check("final_reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_agu_ctrl.md
Name: fft_agu_ctrl

Overview:
- Address-generation and sequencing controller for the in-place radix-2 DIT FFT core.
- On start, walks all N_LOG2 stages × N/2 butterflies and issues per-butterfly operand indices (idx_a, idx_b) plus the twiddle ROM address over a valid/ready handshake.
- Inserts a programmable drain gap between stages so butterfly writeback completes before the next stage reads.
- Sits between the top-level FFT control and the twiddle ROM / sample-RAM port logic.

Parameters:
- DRAIN_CYCLES, 4, idle cycles between the last handshake of a stage and the first issue of the next stage; must be ≥1 (covers butterfly pipeline plus RAM write latency).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin a transform; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the final stage's drain completes
- bf_valid  out  1  butterfly command valid
- bf_ready  in  1  datapath accepts command when bf_valid && bf_ready
- idx_a  out  N_LOG2  upper-leg sample index
- idx_b  out  N_LOG2  lower-leg sample index (= idx_a + 2^stage)
- tw_addr  out  N_LOG2-1  twiddle ROM address (ROM data valid one cycle after the handshake)
- stage  out  STG_W  current stage number 0..N_LOG2-1
- last_bf  out  1  qualifies the final butterfly of the current stage

Behaviour:
- Reset: state=IDLE; k=0, stage=0, drain counter=0; busy=0, done=0, bf_valid=0. idx_a, idx_b, tw_addr and last_bf are 0.
- States:
  - IDLE: start=1 → RUN with k=0, stage=0. start is ignored in every other state.
  - RUN: bf_valid=1. On a handshake, k increments. If k==N/2-1 at the handshake → DRAIN with drain counter loaded to DRAIN_CYCLES-1.
  - DRAIN: bf_valid=0; the counter decrements each cycle. At 0: if stage==N_LOG2-1 → DONE, else stage+1, k=0 → RUN.
  - DONE: done=1 for exactly one cycle, busy=0 → IDLE.
- Addressing: half=1<<stage, pos=k&(half-1), grp=k>>stage.
  - idx_a=(grp<<(stage+1))|pos.
  - idx_b=idx_a|half.
  - tw_addr=pos<<(N_LOG2-1-stage).
  - All are registered outputs of state, valid in the same cycle as bf_valid.
- Handshake: outputs are held stable while bf_valid && !bf_ready. bf_valid never drops in RUN without a handshake.
- last_bf=1 iff k==N/2-1 in RUN.
- Throughput: one butterfly per cycle with bf_ready held high. Total cycles from start to done = 1 + N_LOG2·(N/2 + DRAIN_CYCLES) + 1.
- Boundaries:
  - start asserted in the same cycle done pulses is ignored.
  - start held high continuously restarts only from IDLE, i.e. on the cycle after done.
  - rst mid-RUN or mid-DRAIN returns to IDLE next edge with all outputs at reset values. No partial completion: done does not pulse.
  - bf_ready stalls spanning any number of cycles are legal.
  - k wraps only via the stage transition, never arithmetically.

Optional Feature:
- Macro: FFT_AGU_INVERSE_EN.
- With it defined:
  - Adds input port inverse (1 bit), captured on start acceptance.
  - Adds output tw_conj (1 bit), equal to the captured value for the whole transform, so the datapath negates the twiddle imaginary part for IFFT.
  - tw_conj resets to 0.
- Without it: neither port exists; behaviour is forward-FFT only.

Decomposition:
- fft_consts (existing shared package) provides N, N_LOG2, DW, DW_COMPLEX and complex_t.
- Add to fft_consts: STG_W=$clog2(N_LOG2) (min 1), and typedef agu_state_t {IDLE, RUN, DRAIN, DONE}.
- One natural sub-module: fft_agu_idx. It is purely combinational: (k, stage) → (idx_a, idx_b, tw_addr), registered by the parent.
- The twiddle ROM is instantiated by the datapath, not here.

Test Plan (package N=8, N_LOG2=3, DRAIN_CYCLES=4):
- Reset then idle: rst high 3 cycles, start=0 → busy=0, bf_valid=0, done=0 for 20 cycles.
- Full run, bf_ready=1: start pulse → 12 handshakes in order:
  - stage0 (a,b,tw) = (0,1,0), (2,3,0), (4,5,0), (6,7,0)
  - stage1 = (0,2,0), (1,3,2), (4,6,0), (5,7,2)
  - stage2 = (0,4,0), (1,5,1), (2,6,2), (3,7,3)
  - last_bf on the 4th/8th/12th; done pulses exactly 26 cycles after start.
- Backpressure: bf_ready toggled pseudo-randomly → identical 12-tuple sequence, outputs stable during each stall, no duplicate or dropped tuples.
- Drain spacing: bf_ready=1 → exactly 4 cycles with bf_valid=0 between the stage0→1 and stage1→2 transitions.
- Reset mid-operation: rst asserted during stage1 k=2 → next cycle IDLE, busy=0, no done. A fresh start reproduces the full sequence from (0,1,0).
- Start overlap / inverse: start held high → the second transform begins the cycle after done. With FFT_AGU_INVERSE_EN and inverse=1 at start → tw_conj=1 throughout, 0 after reset.
